// File: rtl/wave_ctrl_pkg.sv
// Shared definitions for the DDS waveform-select front end: mode encodings,
// 50 MHz timing defaults and waveform index names.
package wave_ctrl_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_STEP   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    SAWTOOTH = 2'd2,
    TRIANGLE = 2'd3
  } wave_e;

  localparam int unsigned CNT_MAX_50M = 999_999;
  localparam int unsigned RPT_DLY_50M = 24_999_999;
  localparam int unsigned RPT_PER_50M = 9_999_999;

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser plus saturating stable-low counter,
// giving a one-cycle press strobe and a level "held" flag.
module key_debounce_ch
  import wave_ctrl_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_50M
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press,
  output logic held
);

  localparam int unsigned   CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_ARM = CW'(CNT_MAX - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Strobe is registered so it lines up with the cycle held first rises.
    press_d = !sync2_q && (cnt_q == CNT_ARM);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
  assign held  = (cnt_q == CNT_TOP);

endmodule

// File: rtl/key_mode_sel.sv
// Key front end for the DDS generator: debounced keys drive a one-hot waveform
// select, either directly (key i -> wave i) or by next/prev stepping with auto-repeat.
module key_mode_sel
  import wave_ctrl_pkg::*;
#(
  parameter int unsigned N_KEY   = 4,
  parameter int unsigned CNT_MAX = CNT_MAX_50M,
  parameter int unsigned RPT_DLY = RPT_DLY_50M,
  parameter int unsigned RPT_PER = RPT_PER_50M,
  parameter int unsigned RST_SEL = N_KEY - 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [N_KEY-1:0]         key,
  input  logic                     mode,
  output logic [N_KEY-1:0]         wave_sel,
  output logic [$clog2(N_KEY)-1:0] sel_idx,
  output logic                     sel_chg
);

  localparam int unsigned      IW         = $clog2(N_KEY);
  localparam int unsigned      RW         = cnt_width(RPT_DLY);
  localparam logic [IW-1:0]    IDX_LAST   = IW'(N_KEY - 1);
  localparam logic [IW-1:0]    IDX_RST    = IW'(RST_SEL);
  localparam logic [N_KEY-1:0] WAVE_RST   = N_KEY'(1) << RST_SEL;
  localparam logic [RW-1:0]    RPT_FIRE   = RW'(RPT_DLY);
  localparam logic [RW-1:0]    RPT_RELOAD = RW'(RPT_DLY - RPT_PER + 1);

  logic [N_KEY-1:0] press, held;
  logic             unused_held;

  for (genvar gi = 0; gi < N_KEY; gi++) begin : g_key
    key_debounce_ch #(
      .CNT_MAX (CNT_MAX)
    ) u_deb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_n     (key[gi]),
      .press     (press[gi]),
      .held      (held[gi])
    );
  end

  // Only keys 0/1 have a held meaning; the rest exist for direct-mode presses.
  assign unused_held = ^held;

  logic [IW-1:0]    idx_q, idx_d;
  logic [N_KEY-1:0] wave_q, wave_d;
  logic             chg_q, chg_d;
  logic [RW-1:0]    rpt_q, rpt_d;
  logic             one_held, rpt_fire, step_next, step_prev;

  always_comb begin
    idx_d     = idx_q;
    rpt_d     = '0;
    one_held  = held[0] ^ held[1];
    rpt_fire  = 1'b0;
    step_next = 1'b0;
    step_prev = 1'b0;
    if (mode == MODE_STEP) begin
      // After the first repeat the counter reloads so later ones are RPT_PER apart.
      rpt_fire = one_held && (rpt_q == RPT_FIRE);
      if (one_held) begin
        rpt_d = rpt_fire ? RPT_RELOAD : rpt_q + RW'(1);
      end
      step_next = press[0] | (rpt_fire & held[0]);
      step_prev = press[1] | (rpt_fire & held[1]);
      if (step_next && !step_prev) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else if (step_prev && !step_next) begin
        idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IW'(1);
      end
    end else begin
      for (int i = 0; i < N_KEY; i++) begin
        if (press[i]) idx_d = IW'(i);
      end
    end
    chg_d  = (idx_d != idx_q);
    wave_d = N_KEY'(1) << idx_d;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      idx_q  <= IDX_RST;
      wave_q <= WAVE_RST;
      chg_q  <= 1'b0;
      rpt_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      wave_q <= wave_d;
      chg_q  <= chg_d;
      rpt_q  <= rpt_d;
    end
  end

  assign wave_sel = wave_q;
  assign sel_idx  = idx_q;
  assign sel_chg  = chg_q;

endmodule

// File: tb/tb_key_mode_sel.sv
// Scoreboard bench for key_mode_sel: a run-length key model predicts every
// selection change, a negedge monitor checks each sel_chg against the queue.
module tb_key_mode_sel;

  localparam int NK = 4;
  localparam int CM = 9;
  localparam int RD = 29;
  localparam int RP = 9;
  localparam int RS = 3;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NK-1:0] key       = '1;
  logic          mode      = 1'b0;
  logic [NK-1:0] wave_sel;
  logic [1:0]    sel_idx;
  logic          sel_chg;

  key_mode_sel #(
    .N_KEY   (NK),
    .CNT_MAX (CM),
    .RPT_DLY (RD),
    .RPT_PER (RP),
    .RST_SEL (RS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .mode      (mode),
    .wave_sel  (wave_sel),
    .sel_idx   (sel_idx),
    .sel_chg   (sel_chg)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int due;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_no = 0;
  int   chg_seen = 0;
  int   last_chg_edge = -1;

  // Reference model state: hist[d][i] = length of the low run of key i, d+1 edges ago.
  int   m_idx = RS;
  int   m_k = 0;
  int   hist[3][NK];
  bit   pr[NK];
  bit   hd[NK];
  int   nx_idx, n_held, nr;
  bit   q, fire, nx, pv;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Model: a key press is a run of CM low samples; its effect reaches the outputs 3 edges later.
  always @(posedge sys_clk) begin
    edge_no++;
    if (!sys_rst_n) begin
      m_idx = RS;
      m_k   = 0;
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < NK; i++) hist[d][i] = 0;
    end else begin
      nx_idx = m_idx;
      for (int i = 0; i < NK; i++) begin
        pr[i] = (hist[2][i] == CM);
        hd[i] = (hist[2][i] >= CM);
      end
      n_held = int'(hd[0]) + int'(hd[1]);
      if (mode) begin
        q    = (n_held == 1);
        fire = q && (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0));
        nx   = pr[0] || (fire && hd[0]);
        pv   = pr[1] || (fire && hd[1]);
        if (nx && !pv) nx_idx = (m_idx + 1) % NK;
        else if (pv && !nx) nx_idx = (m_idx + NK - 1) % NK;
        m_k = q ? m_k + 1 : 0;
      end else begin
        for (int i = 0; i < NK; i++) if (pr[i]) nx_idx = i;
        m_k = 0;
      end
      if (nx_idx != m_idx) exp_q.push_back('{due: edge_no, idx: nx_idx});
      m_idx = nx_idx;
      for (int i = 0; i < NK; i++) begin
        nr = key[i] ? 0 : hist[0][i] + 1;
        hist[2][i] = hist[1][i];
        hist[1][i] = hist[0][i];
        hist[0][i] = nr;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (edge_no > 0) begin
      chk("idx_track", int'(sel_idx), m_idx);
      chk("wave_onehot", int'(wave_sel), 1 << m_idx);
      if (sel_chg) begin
        chg_seen++;
        last_chg_edge = edge_no;
        $display("chg edge=%0d idx=%0d wave=%b", edge_no, sel_idx, wave_sel);
        if (exp_q.size() == 0) begin
          chk("chg_unexpected", int'(sel_chg), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("chg_edge", edge_no, e.due);
          chk("chg_idx", int'(sel_idx), e.idx);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= edge_no) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("chg_missing", int'(sel_chg), 1);
      end
    end
  end

  int c0, e0, r0, rr;

  initial begin
    // Reset, then idle
    cyc(3);
    sys_rst_n = 1'b1;
    cyc(1);
    chk("rst_wave", int'(wave_sel), 8);
    chk("rst_idx", int'(sel_idx), 3);
    chk("rst_chg", int'(sel_chg), 0);
    cyc(5);
    chk("idle_wave", int'(wave_sel), 8);
    chk("idle_chg_count", chg_seen, 0);

    // Direct: bounce on key1, then a clean press
    mode = 1'b0;
    c0 = chg_seen;
    for (int i = 0; i < 6; i++) begin
      key[1] = i[0];
      cyc(1);
    end
    key[1] = 1'b0;
    e0 = edge_no + 1;
    cyc(20);
    key = '1;
    cyc(5);
    chk("bounce_one_chg", chg_seen - c0, 1);
    chk("press_latency", last_chg_edge, e0 + CM + 2);
    chk("direct_wave1", int'(wave_sel), 2);

    // Direct: simultaneous key0+key2, then re-press of the current one
    c0 = chg_seen;
    key = 4'b1010;
    cyc(15);
    key = '1;
    cyc(5);
    chk("direct_high_wins", int'(sel_idx), 2);
    chk("direct_simul_chg", chg_seen - c0, 1);
    c0 = chg_seen;
    key[2] = 1'b0;
    cyc(15);
    key = '1;
    cyc(5);
    chk("reselect_no_chg", chg_seen - c0, 0);

    // Step: wrap both ways, then both keys together
    sys_rst_n = 1'b0;
    cyc(2);
    sys_rst_n = 1'b1;
    mode = 1'b1;
    cyc(2);
    key[0] = 1'b0;
    cyc(12);
    key = '1;
    cyc(4);
    chk("step_wrap_next", int'(sel_idx), 0);
    key[1] = 1'b0;
    cyc(12);
    key = '1;
    cyc(4);
    chk("step_wrap_prev", int'(sel_idx), 3);
    c0 = chg_seen;
    key = 4'b1100;
    cyc(12);
    key = '1;
    cyc(4);
    chk("step_both_no_chg", chg_seen - c0, 0);

    // Step: long hold on key0 with auto-repeat, release mid-period
    c0 = chg_seen;
    key[0] = 1'b0;
    e0 = edge_no + 1;
    cyc(71);
    key = '1;
    cyc(40);
    chk("repeat_count", chg_seen - c0, 5);
    chk("repeat_last_edge", last_chg_edge, e0 + CM + 2 + 56);
    chk("repeat_idx", int'(sel_idx), 0);

    // Reset while key0 is held mid-repeat
    key[0] = 1'b0;
    cyc(50);
    sys_rst_n = 1'b0;
    cyc(3);
    sys_rst_n = 1'b1;
    r0 = edge_no + 1;
    cyc(1);
    chk("rel_wave", int'(wave_sel), 8);
    chk("rel_idx", int'(sel_idx), 3);
    chk("rel_chg", int'(sel_chg), 0);
    cyc(15);
    chk("rehold_press_edge", last_chg_edge, r0 + CM + 2);
    chk("rehold_idx", int'(sel_idx), 0);
    key = '1;
    cyc(10);

    // Random segments: bounces, holds, mode flips, short resets
    for (int s = 0; s < 70; s++) begin
      rr = $urandom_range(0, 99);
      if (rr < 6) begin
        sys_rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        sys_rst_n = 1'b1;
      end else if (rr < 20) begin
        mode = ~mode;
        cyc($urandom_range(1, 4));
      end else if (rr < 45) begin
        for (int b = 0; b < 6; b++) begin
          key = 4'($urandom) | 4'($urandom);
          cyc($urandom_range(1, 3));
        end
      end else begin
        key = 4'($urandom) | 4'($urandom);
        cyc($urandom_range(5, 50));
        if ($urandom_range(0, 1) == 1) key = '1;
        cyc($urandom_range(1, 6));
      end
    end
    key = '1;
    cyc(80);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
